// File: rtl/shift_seq8_pkg.sv
// Shared encodings and defaults for the 8-bit
// shift sequencer.
package shift_seq8_pkg;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/mx2.sv
// 2:1 mux cell.
// y = s ? b : a.
module mx2 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  // Plain select.
  always_comb y = s ? b : a;

endmodule

// File: rtl/shift_seq8_shift1.sv
// Single-step 8-bit shifter built from mx2 cells.
// Level 1 picks the fill bit, level 2 the direction.
module shift1_8
  import shift_seq8_pkg::*;
(
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  logic is_lsl;
  logic fill_ar;
  logic fill;

  // Left shift is the only op moving bits upward.
  always_comb is_lsl = (op == OP_LSL);

  // ASR refills with d[7], ROR with d[0].
  mx2 u_fill0 (
    .a (d[WIDTH-1]),
    .b (d[0]),
    .s (op[0]),
    .y (fill_ar)
  );

  // LSR (and unused LSL path) refills with 0.
  mx2 u_fill1 (
    .a (1'b0),
    .b (fill_ar),
    .s (op[1]),
    .y (fill)
  );

  mx2 u_b0 (
    .a (d[1]),
    .b (1'b0),
    .s (is_lsl),
    .y (y[0])
  );

  for (genvar i = 1; i < WIDTH - 1; i++) begin : g_mid
    mx2 u_bi (
      .a (d[i+1]),
      .b (d[i-1]),
      .s (is_lsl),
      .y (y[i])
    );
  end

  mx2 u_bmsb (
    .a (fill),
    .b (d[WIDTH-2]),
    .s (is_lsl),
    .y (y[WIDTH-1])
  );

endmodule

// File: rtl/shift_seq8.sv
// Multi-cycle shift sequencer: one bit per clock,
// req/busy accept, one-cycle done pulse.
module shift_seq8
  import shift_seq8_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] d_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d_out
);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] step;

  shift1_8 u_shift1 (
    .d  (dout_q),
    .op (op_q),
    .y  (step)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_LSL;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dout_q  <= dout_d;
    end
  end

  // Next state, counter and working register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dout_d  = dout_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          dout_d  = d_in;
          op_d    = op;
          cnt_d   = amt;
          state_d = (amt != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        dout_d = step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == AMT_W'(1))
          state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state.
  always_comb begin
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE);
    d_out = dout_q;
  end

endmodule

// File: doc/shift_seq8.md
Name: shift_seq8

Overview:
- Multi-cycle sequencer for the 8-bit shift datapath.
- Accepts one shift request through a req/busy handshake, loads the operand and applies a 1-bit shift per clock for the requested amount.
- Presents the result with a one-cycle done pulse.
- Sits between a control FSM or counter block and the shifter datapath, so the datapath needs only a single-step shifter, not a barrel shifter.

Parameters:
- WIDTH, 8, data width in bits; the design and tests are specified for 8.
- AMT_W, 3, width of the shift-amount field; the maximum amount is 2^AMT_W - 1 = 7.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; sampled only while busy = 0.
- op  in  2  shift operation, sampled with req: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- amt  in  AMT_W  shift amount, sampled with req.
- d_in  in  WIDTH  operand, sampled with req.
- busy  out  1  high whenever the sequencer is not IDLE.
- done  out  1  one-cycle pulse; d_out is valid while done = 1.
- d_out  out  WIDTH  working/result register.

Behaviour:
- Reset (reset_n = 0, takes effect immediately, independent of clk):
  - state = IDLE, d_out = 0x00, cnt = 0, op_q = 00, busy = 0, done = 0.
  - Reset asserted mid-operation aborts the operation; no done pulse is produced.
- State machine: IDLE, SHIFT, DONE. Use a registered state with outputs decoded from state: busy = (state != IDLE), done = (state == DONE).
- IDLE:
  - On an edge with req = 1: d_out <- d_in, op_q <- op, cnt <- amt.
  - Go to SHIFT if amt != 0, otherwise go to DONE.
  - req = 0: stay in IDLE, all registers hold.
- SHIFT, on each edge:
  - d_out <- one-step shift of d_out per op_q; cnt <- cnt - 1.
  - If cnt == 1 before the edge, go to DONE; otherwise stay in SHIFT.
- DONE: lasts exactly one cycle, then goes to IDLE unconditionally. d_out holds and remains holding in IDLE until the next accept.
- One-step shift definitions:
  - LSL: {d[6:0], 0}
  - LSR: {0, d[7:1]}
  - ASR: {d[7], d[7:1]}
  - ROR: {d[0], d[7:1]}
- Latency: with the accept edge as E0, the result is in d_out after edge E0+amt, done is high during the cycle following edge E0+amt, and busy falls after edge E0+amt+1. The amt = 0 case gives done in the cycle right after E0 with d_out = d_in.
- req while busy = 1 (SHIFT or DONE) is ignored: it is not queued, and op/amt/d_in changes have no effect.
- The earliest new accept is the edge after the DONE cycle, so back-to-back requests give a 1-cycle IDLE gap.
- cnt never wraps: decrement occurs only in SHIFT, where cnt >= 1.
- No X propagation: op decode is a full case, and unused encodings do not exist.

Decomposition:
- Package shift_seq8_pkg:
  - op encodings OP_LSL = 2'b00, OP_LSR = 2'b01, OP_ASR = 2'b10, OP_ROR = 2'b11.
  - state encodings S_IDLE = 2'b00, S_SHIFT = 2'b01, S_DONE = 2'b10.
  - WIDTH/AMT_W defaults.
- One sub-module, shift1_8: a combinational single-step shifter (d, op -> y), built per bit from the existing mx2 cells (two mux levels per bit: direction, then fill bit).
- The top level holds the FSM, the cnt down-counter, op_q and the d_out register.

Test Plan:
- LSL, d_in = 0x81, amt = 3, req pulsed at E0 -> busy high from E0; d_out = 0x02, 0x04, 0x08 after E1..E3; done high for exactly the cycle after E3 with d_out = 0x08; busy low after E4.
- ASR, d_in = 0x90, amt = 2 -> d_out = 0xC8 then 0xE4, done with 0xE4. ROR, 0x81, amt = 1 -> 0xC0. LSR, 0x81, amt = 7 -> 0x01 with done after the 7th shift edge.
- amt = 0, d_in = 0x5A, any op -> done in the cycle after the accept edge, d_out = 0x5A, no SHIFT state visited.
- Accept LSL 0x01 amt = 4; hold req = 1 with d_in = 0xFF, op = ROR throughout -> result 0x10 unaffected; the second request is accepted only on the edge after the DONE cycle, and the second result is 0xFF.
- Accept LSR 0xF0 amt = 5; drop reset_n low asynchronously mid-cycle after 2 shifts -> busy, done and d_out go to 0 immediately with no done pulse; after release, a new request completes normally.
- Random regression: 200 random (op, amt, d_in) requests with random req gaps; compare done timing (E0+amt+1) and d_out against a reference model.
